// File: rtl/conv2_window_buf_pkg.sv
// Shared CNN constants for the second conv layer window buffer: default sizes,
// derived shift-chain depth and the FILL/EMIT state encoding.
package conv2_window_buf_pkg;

    localparam int CNN_DATA_W = 12;
    localparam int CNN_IMG_W  = 12;
    localparam int CNN_K      = 5;

    // Samples needed so the oldest window pixel is still held when the newest arrives.
    function automatic int chain_depth(input int img_w, input int k);
        return (k - 1) * img_w + k;
    endfunction

    localparam int CNN_CHAIN_D = chain_depth(CNN_IMG_W, CNN_K);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

endpackage

// File: rtl/conv2_window_buf_line.sv
// Per-channel line chain: raster samples shift through a (K-1)*IMG_W+K deep chain
// and the K*K window taps are picked off at fixed row/column offsets.
module conv2_line_chain
    import conv2_window_buf_pkg::*;
#(
    parameter int DATA_W = CNN_DATA_W,
    parameter int IMG_W  = CNN_IMG_W,
    parameter int K      = CNN_K
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            shift_en,
    input  logic [DATA_W-1:0]               din,
    output logic [K*K-1:0][DATA_W-1:0]      taps
);

    localparam int DEPTH = chain_depth(IMG_W, K);

    // Entry 0 of the chain view is the incoming sample itself, so the taps already
    // include the pixel being accepted and only DEPTH-1 entries need storage.
    logic [DEPTH-2:0][DATA_W-1:0] chain_q;
    logic [DEPTH-1:0][DATA_W-1:0] view;

    assign view = {chain_q, din};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else if (shift_en) begin
            chain_q <= view[DEPTH-2:0];
        end
    end

    // Tap r*K+c is pixel (R-(K-1)+r, C-(K-1)+c): its age is (K-1-r) rows plus (K-1-c) pixels.
    for (genvar r = 0; r < K; r++) begin : g_row
        for (genvar c = 0; c < K; c++) begin : g_col
            assign taps[r*K+c] = view[(K-1-r)*IMG_W + (K-1-c)];
        end
    end

endmodule

// File: rtl/conv2_window_buf.sv
// Three-channel 5x5 sliding window buffer: raster pixels in, one registered window
// pulse per fully-covered output position, with an end-of-frame marker.
module conv2_window_buf
    import conv2_window_buf_pkg::*;
#(
    parameter int DATA_W = CNN_DATA_W,
    parameter int IMG_W  = CNN_IMG_W,
    parameter int K      = CNN_K
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_in,
    input  logic signed [DATA_W-1:0] data_in1,
    input  logic signed [DATA_W-1:0] data_in2,
    input  logic signed [DATA_W-1:0] data_in3,
    output logic signed [DATA_W-1:0] data_out1_0,  data_out1_1,  data_out1_2,  data_out1_3,  data_out1_4,
    output logic signed [DATA_W-1:0] data_out1_5,  data_out1_6,  data_out1_7,  data_out1_8,  data_out1_9,
    output logic signed [DATA_W-1:0] data_out1_10, data_out1_11, data_out1_12, data_out1_13, data_out1_14,
    output logic signed [DATA_W-1:0] data_out1_15, data_out1_16, data_out1_17, data_out1_18, data_out1_19,
    output logic signed [DATA_W-1:0] data_out1_20, data_out1_21, data_out1_22, data_out1_23, data_out1_24,
    output logic signed [DATA_W-1:0] data_out2_0,  data_out2_1,  data_out2_2,  data_out2_3,  data_out2_4,
    output logic signed [DATA_W-1:0] data_out2_5,  data_out2_6,  data_out2_7,  data_out2_8,  data_out2_9,
    output logic signed [DATA_W-1:0] data_out2_10, data_out2_11, data_out2_12, data_out2_13, data_out2_14,
    output logic signed [DATA_W-1:0] data_out2_15, data_out2_16, data_out2_17, data_out2_18, data_out2_19,
    output logic signed [DATA_W-1:0] data_out2_20, data_out2_21, data_out2_22, data_out2_23, data_out2_24,
    output logic signed [DATA_W-1:0] data_out3_0,  data_out3_1,  data_out3_2,  data_out3_3,  data_out3_4,
    output logic signed [DATA_W-1:0] data_out3_5,  data_out3_6,  data_out3_7,  data_out3_8,  data_out3_9,
    output logic signed [DATA_W-1:0] data_out3_10, data_out3_11, data_out3_12, data_out3_13, data_out3_14,
    output logic signed [DATA_W-1:0] data_out3_15, data_out3_16, data_out3_17, data_out3_18, data_out3_19,
    output logic signed [DATA_W-1:0] data_out3_20, data_out3_21, data_out3_22, data_out3_23, data_out3_24,
    output logic                     valid_out_buf,
    output logic                     frame_done
);

    localparam int                CNT_W     = $clog2(IMG_W);
    localparam int                NTAP      = K * K;
    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0]  WIN_START = CNT_W'(K - 1);

    logic [CNT_W-1:0] col_cnt, row_cnt;
    logic [CNT_W-1:0] acc_col, acc_row;
    logic             started;
    logic             win_cond, last_px;
    logic             fresh_q;
    logic [0:0]       state;

    logic [2:0][DATA_W-1:0]            din_v;
    logic [2:0][NTAP-1:0][DATA_W-1:0]  taps;
    logic [2:0][NTAP-1:0][DATA_W-1:0]  win_q;

    // col_cnt/row_cnt hold the last accepted pixel; acc_* is where the incoming one lands.
    always_comb begin
        acc_col = '0;
        acc_row = '0;
        if (started) begin
            if (col_cnt == LAST_IDX) begin
                acc_col = '0;
                acc_row = (row_cnt == LAST_IDX) ? '0 : row_cnt + CNT_W'(1);
            end else begin
                acc_col = col_cnt + CNT_W'(1);
                acc_row = row_cnt;
            end
        end
    end

    assign win_cond = (acc_row >= WIN_START) && (acc_col >= WIN_START);
    assign last_px  = (acc_row == LAST_IDX) && (acc_col == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt    <= '0;
            row_cnt    <= '0;
            started    <= 1'b0;
            state      <= ST_FILL;
            fresh_q    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            fresh_q    <= valid_in;
            frame_done <= valid_in && win_cond && last_px;
            if (valid_in) begin
                col_cnt <= acc_col;
                row_cnt <= acc_row;
                started <= 1'b1;
                state   <= win_cond ? ST_EMIT : ST_FILL;
            end
        end
    end

    // A pulse needs both a fresh acceptance and that acceptance to have completed a window.
    assign valid_out_buf = fresh_q && (state == ST_EMIT);

    assign din_v = {data_in3, data_in2, data_in1};

    for (genvar n = 0; n < 3; n++) begin : g_ch
        conv2_line_chain #(
            .DATA_W (DATA_W),
            .IMG_W  (IMG_W),
            .K      (K)
        ) u_chain (
            .clk      (clk),
            .rst_n    (rst_n),
            .shift_en (valid_in),
            .din      (din_v[n]),
            .taps     (taps[n])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q <= '0;
        end else if (valid_in && win_cond) begin
            win_q <= taps;
        end
    end

    assign {data_out1_24, data_out1_23, data_out1_22, data_out1_21, data_out1_20,
            data_out1_19, data_out1_18, data_out1_17, data_out1_16, data_out1_15,
            data_out1_14, data_out1_13, data_out1_12, data_out1_11, data_out1_10,
            data_out1_9,  data_out1_8,  data_out1_7,  data_out1_6,  data_out1_5,
            data_out1_4,  data_out1_3,  data_out1_2,  data_out1_1,  data_out1_0} = win_q[0];

    assign {data_out2_24, data_out2_23, data_out2_22, data_out2_21, data_out2_20,
            data_out2_19, data_out2_18, data_out2_17, data_out2_16, data_out2_15,
            data_out2_14, data_out2_13, data_out2_12, data_out2_11, data_out2_10,
            data_out2_9,  data_out2_8,  data_out2_7,  data_out2_6,  data_out2_5,
            data_out2_4,  data_out2_3,  data_out2_2,  data_out2_1,  data_out2_0} = win_q[1];

    assign {data_out3_24, data_out3_23, data_out3_22, data_out3_21, data_out3_20,
            data_out3_19, data_out3_18, data_out3_17, data_out3_16, data_out3_15,
            data_out3_14, data_out3_13, data_out3_12, data_out3_11, data_out3_10,
            data_out3_9,  data_out3_8,  data_out3_7,  data_out3_6,  data_out3_5,
            data_out3_4,  data_out3_3,  data_out3_2,  data_out3_1,  data_out3_0} = win_q[2];

endmodule

// File: tb/tb_conv2_window_buf.sv
// Directed bench for conv2_window_buf: per-cycle window model plus a table of
// hand-computed spot values checked against the recorded pulse log.
module tb_conv2_window_buf;

    localparam int DW = 12;
    localparam int IW = 12;
    localparam int KK = 5;
    localparam int NT = KK * KK;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic valid_in = 1'b0;
    logic signed [DW-1:0] d1 = '0, d2 = '0, d3 = '0;
    logic [NT-1:0][DW-1:0] o1, o2, o3;
    logic valid_out_buf, frame_done;

    always #5 clk = ~clk;

    conv2_window_buf dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
        .data_in1(d1), .data_in2(d2), .data_in3(d3),
        .data_out1_0(o1[0]),   .data_out1_1(o1[1]),   .data_out1_2(o1[2]),   .data_out1_3(o1[3]),   .data_out1_4(o1[4]),
        .data_out1_5(o1[5]),   .data_out1_6(o1[6]),   .data_out1_7(o1[7]),   .data_out1_8(o1[8]),   .data_out1_9(o1[9]),
        .data_out1_10(o1[10]), .data_out1_11(o1[11]), .data_out1_12(o1[12]), .data_out1_13(o1[13]), .data_out1_14(o1[14]),
        .data_out1_15(o1[15]), .data_out1_16(o1[16]), .data_out1_17(o1[17]), .data_out1_18(o1[18]), .data_out1_19(o1[19]),
        .data_out1_20(o1[20]), .data_out1_21(o1[21]), .data_out1_22(o1[22]), .data_out1_23(o1[23]), .data_out1_24(o1[24]),
        .data_out2_0(o2[0]),   .data_out2_1(o2[1]),   .data_out2_2(o2[2]),   .data_out2_3(o2[3]),   .data_out2_4(o2[4]),
        .data_out2_5(o2[5]),   .data_out2_6(o2[6]),   .data_out2_7(o2[7]),   .data_out2_8(o2[8]),   .data_out2_9(o2[9]),
        .data_out2_10(o2[10]), .data_out2_11(o2[11]), .data_out2_12(o2[12]), .data_out2_13(o2[13]), .data_out2_14(o2[14]),
        .data_out2_15(o2[15]), .data_out2_16(o2[16]), .data_out2_17(o2[17]), .data_out2_18(o2[18]), .data_out2_19(o2[19]),
        .data_out2_20(o2[20]), .data_out2_21(o2[21]), .data_out2_22(o2[22]), .data_out2_23(o2[23]), .data_out2_24(o2[24]),
        .data_out3_0(o3[0]),   .data_out3_1(o3[1]),   .data_out3_2(o3[2]),   .data_out3_3(o3[3]),   .data_out3_4(o3[4]),
        .data_out3_5(o3[5]),   .data_out3_6(o3[6]),   .data_out3_7(o3[7]),   .data_out3_8(o3[8]),   .data_out3_9(o3[9]),
        .data_out3_10(o3[10]), .data_out3_11(o3[11]), .data_out3_12(o3[12]), .data_out3_13(o3[13]), .data_out3_14(o3[14]),
        .data_out3_15(o3[15]), .data_out3_16(o3[16]), .data_out3_17(o3[17]), .data_out3_18(o3[18]), .data_out3_19(o3[19]),
        .data_out3_20(o3[20]), .data_out3_21(o3[21]), .data_out3_22(o3[22]), .data_out3_23(o3[23]), .data_out3_24(o3[24]),
        .valid_out_buf(valid_out_buf), .frame_done(frame_done)
    );

    typedef struct {
        logic [NT-1:0][DW-1:0] w1, w2, w3;
        logic                  fd;
    } pulse_t;

    typedef struct {
        string name;
        int    tst;
        int    win;
        int    ch;
        int    tap;
        int    exp;
    } spot_t;

    int total = 0;
    int bad = 0;
    int br = 0, bc = 0, mode = 0, off = 0, npulse = 0;
    logic exp_v = 1'b0, exp_fd = 1'b0;
    int exp_r = 0, exp_c = 0, exp_mode = 0, exp_off = 0;
    logic [NT-1:0][DW-1:0] last1 = '0, last2 = '0, last3 = '0;
    pulse_t plog[$];
    pulse_t t1log[$];
    spot_t  spots[$];

    // Channel sample at (r,c): mode 0 is the ramp frame, mode 1 the extreme-value frame.
    function automatic int pix(input int md, input int of, input int ch, input int r, input int c);
        int base;
        base = r * IW + c;
        if (md == 0) begin
            case (ch)
                1:       return base + of;
                2:       return -(base + of);
                default: return 7;
            endcase
        end
        case (ch)
            1:       return (base % 2 == 0) ? -2048 : 2047;
            2:       return (base % 2 == 0) ? 2047 : -2048;
            default: return -2048;
        endcase
    endfunction

    function automatic int sx(input logic [DW-1:0] v);
        return int'($signed(v));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string name);
        total++;
        if (o1 !== '0 || o2 !== '0 || o3 !== '0 || valid_out_buf !== 1'b0 || frame_done !== 1'b0) begin
            bad++;
            $display("FAIL %s act=nonzero(v=%0b fd=%0b o1_0=%0d) exp=all_zero",
                     name, valid_out_buf, frame_done, sx(o1[0]));
        end
    endtask

    task automatic check_cycle();
        chk("valid_out_buf", int'(valid_out_buf), int'(exp_v));
        chk("frame_done", int'(frame_done), int'(exp_v && exp_fd));
        if (valid_out_buf === 1'b1) begin
            pulse_t p;
            p.w1 = o1; p.w2 = o2; p.w3 = o3; p.fd = frame_done;
            plog.push_back(p);
            npulse++;
        end
        if (exp_v) begin
            for (int t = 0; t < NT; t++) begin
                int r, c;
                r = t / KK;
                c = t % KK;
                chk("tap_ch1", sx(o1[t]), pix(exp_mode, exp_off, 1, exp_r - 4 + r, exp_c - 4 + c));
                chk("tap_ch2", sx(o2[t]), pix(exp_mode, exp_off, 2, exp_r - 4 + r, exp_c - 4 + c));
                chk("tap_ch3", sx(o3[t]), pix(exp_mode, exp_off, 3, exp_r - 4 + r, exp_c - 4 + c));
            end
            last1 = o1; last2 = o2; last3 = o3;
        end else begin
            total++;
            if (o1 !== last1 || o2 !== last2 || o3 !== last3) begin
                bad++;
                $display("FAIL hold act_o1_0=%0d exp_o1_0=%0d", sx(o1[0]), sx(last1[0]));
            end
        end
    endtask

    // Drive one cycle (pixel or bubble) right after a falling edge, check at the next one.
    task automatic step(input logic v);
        valid_in = v;
        if (v) begin
            d1 = DW'(pix(mode, off, 1, br, bc));
            d2 = DW'(pix(mode, off, 2, br, bc));
            d3 = DW'(pix(mode, off, 3, br, bc));
            exp_v = (br >= KK - 1) && (bc >= KK - 1);
            exp_fd = (br == IW - 1) && (bc == IW - 1);
            exp_r = br; exp_c = bc; exp_mode = mode; exp_off = off;
            if (bc == IW - 1) begin
                bc = 0;
                br = (br == IW - 1) ? 0 : br + 1;
            end else begin
                bc++;
            end
        end else begin
            exp_v = 1'b0;
        end
        @(negedge clk);
        check_cycle();
    endtask

    task automatic frame(input logic toggle);
        for (int i = 0; i < IW * IW; i++) begin
            step(1'b1);
            if (toggle) step(1'b0);
        end
    endtask

    task automatic apply_spots(input int tst);
        foreach (spots[i]) begin
            if (spots[i].tst == tst) begin
                if (spots[i].win >= plog.size()) begin
                    chk(spots[i].name, -99999, spots[i].exp);
                end else begin
                    logic [NT-1:0][DW-1:0] w;
                    w = (spots[i].ch == 1) ? plog[spots[i].win].w1 :
                        (spots[i].ch == 2) ? plog[spots[i].win].w2 : plog[spots[i].win].w3;
                    chk(spots[i].name, sx(w[spots[i].tap]), spots[i].exp);
                end
            end
        end
    endtask

    task automatic cmp_log(input string name);
        total++;
        if (plog.size() != t1log.size()) begin
            bad++;
            $display("FAIL %s act_len=%0d exp_len=%0d", name, plog.size(), t1log.size());
        end else begin
            foreach (plog[i]) begin
                if (plog[i].w1 !== t1log[i].w1 || plog[i].w2 !== t1log[i].w2 || plog[i].w3 !== t1log[i].w3) begin
                    bad++;
                    $display("FAIL %s window=%0d act_o1_0=%0d exp_o1_0=%0d",
                             name, i, sx(plog[i].w1[0]), sx(t1log[i].w1[0]));
                    break;
                end
            end
        end
    endtask

    task automatic begin_test();
        plog.delete();
        npulse = 0;
    endtask

    initial begin
        spots.push_back('{"t1_w0_o1_0",    1, 0,   1, 0,  0});
        spots.push_back('{"t1_w0_o1_24",   1, 0,   1, 24, 52});
        spots.push_back('{"t1_w0_o2_24",   1, 0,   2, 24, -52});
        spots.push_back('{"t1_w0_o3_0",    1, 0,   3, 0,  7});
        spots.push_back('{"t1_w0_o3_12",   1, 0,   3, 12, 7});
        spots.push_back('{"t1_w0_o3_24",   1, 0,   3, 24, 7});
        spots.push_back('{"t1_w7_o1_24",   1, 7,   1, 24, 59});
        spots.push_back('{"t1_w8_o1_0",    1, 8,   1, 0,  12});
        spots.push_back('{"t1_w8_o1_24",   1, 8,   1, 24, 64});
        spots.push_back('{"t1_w63_o1_0",   1, 63,  1, 0,  91});
        spots.push_back('{"t1_w63_o1_24",  1, 63,  1, 24, 143});
        spots.push_back('{"t3_w63_o1_24",  3, 63,  1, 24, 143});
        spots.push_back('{"t3_w64_o1_0",   3, 64,  1, 0,  1});
        spots.push_back('{"t3_w127_o1_24", 3, 127, 1, 24, 144});
        spots.push_back('{"t5_w0_o1_0",    5, 0,   1, 0,  -2048});
        spots.push_back('{"t5_w0_o1_23",   5, 0,   1, 23, 2047});
        spots.push_back('{"t5_w0_o2_23",   5, 0,   2, 23, -2048});
        spots.push_back('{"t5_w0_o2_24",   5, 0,   2, 24, 2047});
        spots.push_back('{"t5_w0_o3_12",   5, 0,   3, 12, -2048});
        spots.push_back('{"t5_w1_o1_0",    5, 1,   1, 0,  2047});

        // Reset state
        repeat (3) @(negedge clk);
        chk_zero("reset_state");
        rst_n = 1'b1;

        // Ramp frame, back-to-back pixels
        begin_test();
        frame(1'b0);
        step(1'b0);
        chk("t1_pulses", npulse, 64);
        apply_spots(1);
        if (plog.size() == 64) chk("t1_last_fd", int'(plog[63].fd), 1);
        else chk("t1_last_fd", -1, 1);
        t1log = plog;

        // Same frame with valid_in toggling every cycle
        begin_test();
        frame(1'b1);
        chk("t2_pulses", npulse, 64);
        cmp_log("t2_same_windows");

        // Two frames back-to-back, second offset by one
        begin_test();
        off = 0;
        frame(1'b0);
        off = 1;
        frame(1'b0);
        off = 0;
        step(1'b0);
        chk("t3_pulses", npulse, 128);
        apply_spots(3);
        if (plog.size() == 128) begin
            chk("t3_fd_63", int'(plog[63].fd), 1);
            chk("t3_fd_127", int'(plog[127].fd), 1);
            chk("t3_fd_64", int'(plog[64].fd), 0);
        end else begin
            chk("t3_fd", plog.size(), 128);
        end

        // Reset mid-frame after 70 pixels, then a clean frame
        for (int i = 0; i < 70; i++) step(1'b1);
        valid_in = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_zero("t4_async_reset");
        @(negedge clk);
        chk_zero("t4_in_reset");
        rst_n = 1'b1;
        br = 0; bc = 0;
        exp_v = 1'b0;
        last1 = '0; last2 = '0; last3 = '0;
        begin_test();
        frame(1'b0);
        step(1'b0);
        chk("t4_pulses", npulse, 64);
        cmp_log("t4_same_windows");

        // Extreme alternating samples
        begin_test();
        mode = 1;
        frame(1'b0);
        step(1'b0);
        chk("t5_pulses", npulse, 64);
        apply_spots(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
